mux_rr_feeder: RTL and testbench



---
 rtl/mux_rr_feeder.sv | 148 ++++++++++++++
 tb/tb_mux_rr_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: control stage in front of a 2:1 WIDTH-bit mux.
// Each channel has one hold register fed by a valid/ready handshake.
// The two channels share the mux output through round-robin arbitration.
// y_valid marks the cycles where Y = S ? I1 : I0 carries a word.
// One served counter per channel counts the words taken downstream.
module mux_rr_feeder #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic [WIDTH-1:0] I0,
    output logic [WIDTH-1:0] I1,
    output logic             S,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t state;
    logic   full0;
    logic   full1;
    logic   last;   // channel served most recently; the other one wins a tie

    logic   load0;
    logic   load1;
    logic   xfer0;
    logic   xfer1;

    // A channel can take a new word only when its hold register is empty
    assign in0_ready = ~full0;
    assign in1_ready = ~full1;

    assign load0 = in0_valid & ~full0;
    assign load1 = in1_valid & ~full1;
    assign xfer0 = (state == SEND0) & y_ready;
    assign xfer1 = (state == SEND1) & y_ready;

    // Channel 0 hold register: load on handshake, empty on transfer
    // NOTE: the data registers are reset as well, so I0/I1 never show stale
    // words after reset; sequential state always uses non-blocking (<=).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            I0    <= '0;
            full0 <= 1'b0;
        end else if (load0) begin
            I0    <= in0_data;
            full0 <= 1'b1;
        end else if (xfer0) begin
            full0 <= 1'b0;
        end
    end

    // Channel 1 hold register: load on handshake, empty on transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            I1    <= '0;
            full1 <= 1'b0;
        end else if (load1) begin
            I1    <= in1_data;
            full1 <= 1'b1;
        end else if (xfer1) begin
            full1 <= 1'b0;
        end
    end

    // Served counters, one increment per accepted word, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (xfer0) cnt0 <= cnt0 + CNT_W'(1);
            if (xfer1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

    // Arbiter FSM with registered select and valid outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            S       <= 1'b0;
            y_valid <= 1'b0;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Grant from the registered full flags only
                    if ((full0 & full1 & last) | (full0 & ~full1)) begin
                        state   <= SEND0;
                        S       <= 1'b0;
                        y_valid <= 1'b1;
                    end else if (full1) begin
                        state   <= SEND1;
                        S       <= 1'b1;
                        y_valid <= 1'b1;
                    end
                end
                SEND0: begin
                    if (y_ready) begin
                        last <= 1'b0;
                        // A word landing in channel 1 at this same edge is
                        // granted immediately, giving bubble-free alternation
                        if (full1 | load1) begin
                            state   <= SEND1;
                            S       <= 1'b1;
                            y_valid <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            y_valid <= 1'b0;
                        end
                    end
                end
                SEND1: begin
                    if (y_ready) begin
                        last <= 1'b1;
                        if (full0 | load0) begin
                            state   <= SEND0;
                            S       <= 1'b0;
                            y_valid <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            y_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Testbench for mux_rr_feeder: directed vector table, hand-written
// reset/wrap/fairness sequences and a randomized run against a
// cycle-level reference model of the arbitration rules.
module tb_mux_rr_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid, y_ready;
    logic [15:0] in0_data, in1_data;
    logic        in0_ready, in1_ready, S, y_valid;
    logic [15:0] I0, I1;
    logic [7:0]  cnt0, cnt1;

    // Second instance with 2-bit counters for the wrap check
    logic        w_in0_ready, w_in1_ready, w_S, w_y_valid;
    logic [15:0] w_I0, w_I1;
    logic [1:0]  w_cnt0, w_cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_rr_feeder u_dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .I0(I0), .I1(I1), .S(S), .y_valid(y_valid), .y_ready(y_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    mux_rr_feeder #(.WIDTH(16), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(w_in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(w_in1_ready), .in1_data(in1_data),
        .I0(w_I0), .I1(w_I1), .S(w_S), .y_valid(w_y_valid), .y_ready(y_ready),
        .cnt0(w_cnt0), .cnt1(w_cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] act_vec();
        return {8'h0, I0, I1, S, y_valid, in0_ready, in1_ready, cnt0, cnt1, w_cnt0, w_cnt1};
    endfunction

    // ---------------- reference model ----------------
    // Holds: per-channel occupancy and word, the channel currently shown
    // on Y (-1 = none), the select value, round-robin memory, served counts.
    int          m_full [2];
    logic [15:0] m_word [2];
    int          m_grant;
    logic        m_sel;
    int          m_last;
    int          m_cnt  [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0;
            m_word[i] = '0;
            m_cnt[i]  = 0;
        end
        m_grant = -1;
        m_sel   = 1'b0;
        m_last  = 1;
    endfunction

    function automatic logic [63:0] exp_vec();
        logic [7:0] c0, c1;
        c0 = 8'(m_cnt[0] % 256);
        c1 = 8'(m_cnt[1] % 256);
        return {8'h0, m_word[0], m_word[1], m_sel, logic'(m_grant >= 0),
                logic'(m_full[0] == 0), logic'(m_full[1] == 0),
                c0, c1, 2'(m_cnt[0] % 4), 2'(m_cnt[1] % 4)};
    endfunction

    function automatic void model_clock(input logic v0, input logic [15:0] d0,
                                        input logic v1, input logic [15:0] d1,
                                        input logic yr);
        int accept [2];
        int nxt;
        accept[0] = (v0 && m_full[0] == 0) ? 1 : 0;
        accept[1] = (v1 && m_full[1] == 0) ? 1 : 0;
        nxt = m_grant;
        if (m_grant < 0) begin
            if (m_full[0] != 0 && m_full[1] != 0) nxt = 1 - m_last;
            else if (m_full[0] != 0)              nxt = 0;
            else if (m_full[1] != 0)              nxt = 1;
        end else if (yr) begin
            int cur, oth;
            cur = m_grant;
            oth = 1 - cur;
            m_full[cur] = 0;
            m_last      = cur;
            m_cnt[cur]  = m_cnt[cur] + 1;
            nxt = (m_full[oth] != 0 || accept[oth] != 0) ? oth : -1;
        end
        if (accept[0] != 0) begin m_full[0] = 1; m_word[0] = d0; end
        if (accept[1] != 0) begin m_full[1] = 1; m_word[1] = d1; end
        m_grant = nxt;
        if (nxt >= 0) m_sel = (nxt == 1);
    endfunction

    // One cycle: drive at negedge, compare current outputs, advance model+DUT
    task automatic step(input logic v0, input logic [15:0] d0,
                        input logic v1, input logic [15:0] d1, input logic yr);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        y_ready   = yr;
        check("model", act_vec(), exp_vec());
        model_clock(v0, d0, v1, d1, yr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        in0_valid = 0; in1_valid = 0; y_ready = 0;
        in0_data = '0; in1_data = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        yr;
        logic [15:0] e_i0;
        logic [15:0] e_i1;
        logic        e_s;
        logic        e_yv;
        logic        e_r0;
        logic        e_r1;
        logic [7:0]  e_c0;
        logic [7:0]  e_c1;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic v0, input logic [15:0] d0,
                                input logic v1, input logic [15:0] d1, input logic yr,
                                input logic [15:0] i0, input logic [15:0] i1,
                                input logic s, input logic yv, input logic r0, input logic r1,
                                input logic [7:0] c0, input logic [7:0] c1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.yr = yr;
        v.e_i0 = i0; v.e_i1 = i1; v.e_s = s; v.e_yv = yv;
        v.e_r0 = r0; v.e_r1 = r1; v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_s;
        bit          seen;
        int          diff;
        int          guard;

        //            inputs                          expected after the edge
        // tie from reset: ch0 first, then ch1 back-to-back
        vt[0]  = mk(1, 16'h00AF, 1, 16'h00FA, 1,  16'h00AF, 16'h00FA, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h00AF, 16'h00FA, 0, 1, 0, 0, 0, 0);
        vt[2]  = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h00AF, 16'h00FA, 1, 1, 1, 0, 1, 0);
        vt[3]  = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h00AF, 16'h00FA, 1, 0, 1, 1, 1, 1);
        // single channel with one idle cycle after the load
        vt[4]  = mk(1, 16'h00AF, 0, 16'h0000, 0,  16'h00AF, 16'h00FA, 1, 0, 0, 1, 1, 1);
        vt[5]  = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h00AF, 16'h00FA, 0, 1, 0, 1, 1, 1);
        vt[6]  = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h00AF, 16'h00FA, 0, 0, 1, 1, 2, 1);
        // backpressure on SEND1 while channel 0 loads
        vt[7]  = mk(0, 16'h0000, 1, 16'h00FA, 0,  16'h00AF, 16'h00FA, 0, 0, 1, 0, 2, 1);
        vt[8]  = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h00AF, 16'h00FA, 1, 1, 1, 0, 2, 1);
        vt[9]  = mk(1, 16'h1234, 0, 16'h0000, 0,  16'h1234, 16'h00FA, 1, 1, 0, 0, 2, 1);
        vt[10] = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h1234, 16'h00FA, 1, 1, 0, 0, 2, 1);
        vt[11] = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h1234, 16'h00FA, 1, 1, 0, 0, 2, 1);
        vt[12] = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h1234, 16'h00FA, 1, 1, 0, 0, 2, 1);
        vt[13] = mk(0, 16'h0000, 0, 16'h0000, 0,  16'h1234, 16'h00FA, 1, 1, 0, 0, 2, 1);
        vt[14] = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h1234, 16'h00FA, 0, 1, 0, 1, 2, 2);
        vt[15] = mk(0, 16'h0000, 0, 16'h0000, 1,  16'h1234, 16'h00FA, 0, 0, 1, 1, 3, 2);

        // Reset state
        reset_dut();
        check("reset_state", act_vec(), {8'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1,
                                          8'h0, 8'h0, 2'h0, 2'h0});

        // Directed table
        for (int i = 0; i < 16; i++) begin
            in0_valid = vt[i].v0; in0_data = vt[i].d0;
            in1_valid = vt[i].v1; in1_data = vt[i].d1;
            y_ready   = vt[i].yr;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), act_vec(),
                  {8'h0, vt[i].e_i0, vt[i].e_i1, vt[i].e_s, vt[i].e_yv, vt[i].e_r0, vt[i].e_r1,
                   vt[i].e_c0, vt[i].e_c1, vt[i].e_c0[1:0], vt[i].e_c1[1:0]});
        end

        // Asynchronous reset in the middle of SEND0
        reset_dut();
        step(1, 16'h1111, 1, 16'h2222, 0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        check("pre_rst_send0", {62'h0, y_valid, S}, {62'h0, 1'b1, 1'b0});
        #2 rst = 1'b1;
        #1;
        check("async_rst", {44'h0, y_valid, S, in0_ready, in1_ready, cnt0, cnt1},
              {44'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 8'h0});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 16'hAAAA, 1, 16'h5555, 0);
        step(0, 16'h0000, 0, 16'h0000, 0);
        check("tie_after_rst", {47'h0, y_valid, S, I0}, {47'h0, 1'b1, 1'b0, 16'hAAAA});
        step(0, 16'h0000, 0, 16'h0000, 1);

        // Counter wrap on the 2-bit instance: five channel-0 words
        reset_dut();
        guard = 0;
        while (m_cnt[0] < 5 && guard < 60) begin
            step(1, 16'($urandom), 0, 16'h0000, 1);
            guard++;
        end
        check("wrap_cnt0_w2", {62'h0, w_cnt0}, 64'd1);
        check("served_cnt0", {56'h0, cnt0}, 64'd5);

        // Randomized run against the reference model
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 3) != 0), 16'($urandom),
                 logic'($urandom_range(0, 3) != 0), 16'($urandom),
                 logic'($urandom_range(0, 9) < 7));
        end
        check("rand_final", act_vec(), exp_vec());

        // Fairness: both channels always offering, consumer always ready
        reset_dut();
        seen   = 0;
        prev_s = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step(1, 16'($urandom), 1, 16'($urandom), 1);
            if (y_valid) begin
                if (seen) check("alternate", {63'h0, S}, {63'h0, ~prev_s});
                prev_s = S;
                seen   = 1;
            end else if (seen) begin
                check("no_bubble", {63'h0, y_valid}, 64'd1);
            end
        end
        diff = int'(cnt0) - int'(cnt1);
        check("fair_diff", {63'h0, logic'(diff >= -1 && diff <= 1)}, 64'd1);
        check("fair_total", {56'h0, cnt0 + cnt1}, {56'h0, 8'(m_cnt[0] + m_cnt[1])});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
